// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction memory request/response bundle for fetch_ctrl
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Fetch unit side: issues requests, receives responses.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Memory side: receives requests, returns responses.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch controller; optional perf counters under FETCH_CTRL_PERF_CNT_EN
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic              clk,
  input  logic              rst,
  fetch_ctrl_if.master      imem,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              stall,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr
`ifdef FETCH_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  // FETCH: may issue; WAIT: one request outstanding; DRAIN: outstanding
  // response belongs to a squashed path and must be swallowed.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;

  logic slot_free;
  logic consume;
  logic issue;
  logic fill;

  // The slot can accept a new word if it is empty or is being drained this cycle.
  assign slot_free = !if_valid || !stall;
  assign consume   = if_valid && !stall;

  // A request is only launched when its result is guaranteed a home; a
  // redirect in the same cycle would make the current pc stale.
  assign issue = (state == FETCH) && slot_free && !redirect_valid && !rst;

  // A response only lands in the slot if nothing squashed it.
  assign fill = (state == WAIT) && imem.imem_ack && !redirect_valid;

  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc;

  // Fetch state machine, pc tracking and the registered output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_instr <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          // Any ack seen here has no matching request and is ignored.
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (issue) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            // If the response arrives together with the redirect it is
            // already retired, so no drain is needed.
            state <= imem.imem_ack ? FETCH : DRAIN;
          end else if (imem.imem_ack) begin
            pc    <= pc + PC_STEP;
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end
          if (imem.imem_ack) begin
            state <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase

      // Redirect beats fill, fill beats consumption.
      if (redirect_valid) begin
        if_valid <= 1'b0;
      end else if (fill) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_instr <= imem.imem_rdata;
      end else if (consume) begin
        if_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_CTRL_PERF_CNT_EN
  // Count delivered instructions and cycles the held word is blocked downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (fill) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (if_valid && stall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - vector table plus scoreboarded random-stall stream for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_instr;

  fetch_ctrl_if m_if ();
  fetch_ctrl_if w_if ();

`ifdef FETCH_CTRL_PERF_CNT_EN
  logic [31:0] m_pfetch, m_pstall, w_pfetch, w_pstall;
`endif

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (m_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef FETCH_CTRL_PERF_CNT_EN
    ,
    .perf_fetch_cnt (m_pfetch),
    .perf_stall_cnt (m_pstall)
`endif
  );

  // Second instance only exercises pc wrap-around with a free-running memory.
  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFF), .PC_STEP(32'd1)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem           (w_if),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .stall          (1'b0),
    .if_valid       (w_valid),
    .if_pc          (w_pc),
    .if_instr       (w_instr)
`ifdef FETCH_CTRL_PERF_CNT_EN
    ,
    .perf_fetch_cnt (w_pfetch),
    .perf_stall_cnt (w_pstall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        rv;
    logic [31:0] rpc;
    logic        stall;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        chk;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  vec_t        vecs[$];
  sb_t         exp_q[$];
  int          n_cmp;
  int          n_fail;
  logic        w_pend;
  int          w_seen;
  logic [31:0] w_addrs[2];

  function automatic void add(input logic r, input logic a, input logic [31:0] rd,
                              input logic rv, input logic [31:0] rp, input logic st,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic ev, input logic [31:0] epc,
                              input logic [31:0] einstr, input logic chk);
    vec_t v;
    v.rst = r; v.ack = a; v.rdata = rd; v.rv = rv; v.rpc = rp; v.stall = st;
    v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.epc = epc; v.einstr = einstr;
    v.chk = chk;
    vecs.push_back(v);
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, let combinational outputs settle, sample.
  task automatic drive(input logic r, input logic a, input logic [31:0] rd,
                       input logic rv, input logic [31:0] rp, input logic st);
    @(negedge clk);
    rst                = r;
    m_if.imem_ack      = a;
    m_if.imem_rdata    = rd;
    redirect_valid     = rv;
    redirect_pc        = rp;
    stall              = st;
    w_if.imem_ack      = w_pend;
    w_if.imem_rdata    = w_if.imem_addr + 32'h100;
    #1;
    w_pend = w_if.imem_req;
    if (w_if.imem_req && w_seen < 2) begin
      w_addrs[w_seen] = w_if.imem_addr;
      w_seen++;
    end
  endtask

  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    int          lat;
    logic [31:0] exp_pc;
    logic        st;
    logic        ack_now;
    int          delivered;
    sb_t         e;
`ifdef FETCH_CTRL_PERF_CNT_EN
    logic [31:0] s0, f0;
`endif

    n_cmp = 0; n_fail = 0;
    w_pend = 1'b0; w_seen = 0;
    w_addrs[0] = 32'h1234_5678; w_addrs[1] = 32'h1234_5678;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    m_if.imem_ack = 1'b0; m_if.imem_rdata = 32'h0;
    w_if.imem_ack = 1'b0; w_if.imem_rdata = 32'h0;

    //   rst ack rdata    rv rpc    st | req addr    v  pc     instr   chk
    add(1, 0, 32'h0,    0, 32'h0,  0,  0, 32'h0,   0, 32'h0,  32'h0,   1);
    add(0, 0, 32'h0,    0, 32'h0,  0,  1, 32'h0,   0, 32'h0,  32'h0,   1);
    add(0, 1, 32'h100,  0, 32'h0,  0,  0, 32'h0,   0, 32'h0,  32'h0,   1);
    add(0, 0, 32'h0,    0, 32'h0,  0,  1, 32'h1,   1, 32'h0,  32'h100, 1);
    add(0, 1, 32'h101,  0, 32'h0,  0,  0, 32'h1,   0, 32'h0,  32'h0,   0);
    add(0, 0, 32'h0,    0, 32'h0,  0,  1, 32'h2,   1, 32'h1,  32'h101, 1);
    add(0, 1, 32'h102,  0, 32'h0,  0,  0, 32'h2,   0, 32'h0,  32'h0,   0);
    for (int k = 0; k < 5; k++)
      add(0, 0, 32'h0,  0, 32'h0,  1,  0, 32'h3,   1, 32'h2,  32'h102, 1);
    add(0, 0, 32'h0,    0, 32'h0,  0,  1, 32'h3,   1, 32'h2,  32'h102, 1);
    add(0, 0, 32'h0,    1, 32'h40, 0,  0, 32'h3,   0, 32'h0,  32'h0,   0);
    add(0, 0, 32'h0,    0, 32'h0,  0,  0, 32'h40,  0, 32'h0,  32'h0,   0);
    add(0, 1, 32'h103,  0, 32'h0,  0,  0, 32'h40,  0, 32'h0,  32'h0,   0);
    add(0, 0, 32'h0,    0, 32'h0,  0,  1, 32'h40,  0, 32'h0,  32'h0,   0);
    add(0, 1, 32'h140,  0, 32'h0,  0,  0, 32'h40,  0, 32'h0,  32'h0,   0);
    add(0, 0, 32'h0,    0, 32'h0,  0,  1, 32'h41,  1, 32'h40, 32'h140, 1);
    add(0, 1, 32'h141,  1, 32'h80, 0,  0, 32'h41,  0, 32'h0,  32'h0,   0);
    add(0, 0, 32'h0,    0, 32'h0,  0,  1, 32'h80,  0, 32'h0,  32'h0,   0);
    add(0, 1, 32'h180,  0, 32'h0,  0,  0, 32'h80,  0, 32'h0,  32'h0,   0);
    add(0, 0, 32'h0,    1, 32'hC0, 1,  0, 32'h81,  1, 32'h80, 32'h180, 1);
    add(0, 0, 32'h0,    0, 32'h0,  1,  1, 32'hC0,  0, 32'h0,  32'h0,   0);
    add(0, 0, 32'h0,    1, 32'hD0, 0,  0, 32'hC0,  0, 32'h0,  32'h0,   0);
    add(0, 0, 32'h0,    1, 32'hE0, 0,  0, 32'hD0,  0, 32'h0,  32'h0,   0);
    add(0, 1, 32'h1C0,  0, 32'h0,  0,  0, 32'hE0,  0, 32'h0,  32'h0,   0);
    add(0, 1, 32'hDEAD, 0, 32'h0,  0,  1, 32'hE0,  0, 32'h0,  32'h0,   0);
    add(0, 0, 32'h0,    0, 32'h0,  0,  0, 32'hE0,  0, 32'h0,  32'h0,   0);
    add(0, 1, 32'h1E0,  0, 32'h0,  0,  0, 32'hE0,  0, 32'h0,  32'h0,   0);
    add(0, 0, 32'h0,    0, 32'h0,  1,  0, 32'hE1,  1, 32'hE0, 32'h1E0, 1);
    add(0, 0, 32'h0,    0, 32'h0,  0,  1, 32'hE1,  1, 32'hE0, 32'h1E0, 1);
    add(1, 0, 32'h0,    0, 32'h0,  0,  0, 32'hE1,  0, 32'h0,  32'h0,   0);
    add(0, 1, 32'h1E1,  0, 32'h0,  0,  1, 32'h0,   0, 32'h0,  32'h0,   1);
    add(0, 0, 32'h0,    0, 32'h0,  0,  0, 32'h0,   0, 32'h0,  32'h0,   0);
    add(0, 1, 32'h100,  0, 32'h0,  0,  0, 32'h0,   0, 32'h0,  32'h0,   0);
    add(0, 0, 32'h0,    0, 32'h0,  0,  1, 32'h1,   1, 32'h0,  32'h100, 1);

    // Cycle-exact vectors: reset, streaming, stall hold, redirects, drain, mid-request reset.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].rv, vecs[i].rpc, vecs[i].stall);
      chk32($sformatf("v%0d_req", i), {31'h0, m_if.imem_req}, {31'h0, vecs[i].ereq});
      chk32($sformatf("v%0d_addr", i), m_if.imem_addr, vecs[i].eaddr);
      chk32($sformatf("v%0d_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].ev});
      if (vecs[i].chk) begin
        chk32($sformatf("v%0d_pc", i), if_pc, vecs[i].epc);
        chk32($sformatf("v%0d_instr", i), if_instr, vecs[i].einstr);
      end
`ifdef FETCH_CTRL_PERF_CNT_EN
      if (i == 7)  s0 = m_pstall;
      if (i == 12) chk32("perf_stall_5", m_pstall - s0, 32'd5);
      if (i == 13) f0 = m_pfetch;
      if (i == 18) chk32("perf_fetch_drop", m_pfetch - f0, 32'd1);
`endif
    end

    chk32("wrap_addr0", w_addrs[0], 32'hFFFF_FFFF);
    chk32("wrap_addr1", w_addrs[1], 32'h0);

    // Scoreboarded stream: random stall, 1..3 cycle memory, no redirects.
    drive(1, 0, 32'h0, 0, 32'h0, 0);
    drive(1, 0, 32'h0, 0, 32'h0, 0);
    pend = 1'b0; pend_addr = 32'h0; lat = 0; exp_pc = 32'h0; delivered = 0;
    for (int c = 0; c < 400; c++) begin
      st      = ($urandom_range(0, 3) == 0);
      ack_now = pend && (lat == 0);
      drive(0, ack_now, pend_addr + 32'h100, 0, 32'h0, st);
      if (ack_now) pend = 1'b0;
      else if (pend) lat--;
      if (m_if.imem_req) begin
        chk32("sb_one_outstanding", {31'h0, pend}, 32'h0);
        chk32("sb_addr", m_if.imem_addr, exp_pc);
        e.pc = exp_pc; e.instr = exp_pc + 32'h100;
        exp_q.push_back(e);
        pend = 1'b1; pend_addr = m_if.imem_addr; lat = $urandom_range(0, 2);
        exp_pc = exp_pc + 32'd1;
      end
      if (if_valid && stall)
        chk32("sb_stall_no_req", {31'h0, m_if.imem_req}, 32'h0);
      if (if_valid && !stall) begin
        if (exp_q.size() == 0) begin
          chk32("sb_underflow", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk32("sb_pc", if_pc, e.pc);
          chk32("sb_instr", if_instr, e.instr);
          delivered++;
        end
      end
    end
    n_cmp++;
    if (delivered < 40) begin
      n_fail++;
      $display("FAIL sb_throughput: actual=%0d required>=40", delivered);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
